// File: rtl/mem_pkg.sv
// Shared types for the memory stage: op/size encodings, FSM states and the
// latched request record. Also used by the ALU and decode stages.
package mem_pkg;

    localparam int unsigned XLEN    = 64;   // data-memory word / address width
    localparam int unsigned DATA_W  = 128;  // ALU result / writeback width
    localparam int unsigned FLAGS_W = 64;   // flags carried with each result
    localparam int unsigned TMO_W   = 16;   // ack timeout counter width

    typedef enum logic [1:0] {
        MEMOP_NONE  = 2'd0,
        MEMOP_LOAD  = 2'd1,
        MEMOP_STORE = 2'd2,
        MEMOP_RSVD  = 2'd3   // decoded as NONE
    } memop_t;

    typedef enum logic [1:0] {
        MSZ_BYTE  = 2'd0,
        MSZ_WORD  = 2'd1,
        MSZ_DWORD = 2'd2,
        MSZ_QWORD = 2'd3
    } memsize_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } mem_state_t;

    // Fields kept for the writeback record while an access is outstanding.
    typedef struct packed {
        memop_t               op;
        memsize_t             size;
        logic                 sext;
        logic [FLAGS_W-1:0]   rflags;
    } mem_lat_t;

endpackage

// File: rtl/mem_stage_load_extend.sv
// Load data formatter: truncates raw read data to the access size, then
// sign- or zero-extends it back to 64 bits.
//   rdata   : raw data returned by memory
//   size    : access size
//   sext    : 1 = sign-extend, 0 = zero-extend
//   value_c : extended value (combinational)
module load_extend
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  memsize_t        size,
    input  logic            sext,
    output logic [XLEN-1:0] value_c
);

    always_comb begin
        value_c = rdata;
        unique case (size)
            MSZ_BYTE:  value_c = {{56{sext & rdata[7]}},  rdata[7:0]};
            MSZ_WORD:  value_c = {{48{sext & rdata[15]}}, rdata[15:0]};
            MSZ_DWORD: value_c = {{32{sext & rdata[31]}}, rdata[31:0]};
            MSZ_QWORD: value_c = rdata;
            default:   value_c = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage behind the ALU. Non-memory results pass through with
// one cycle of latency; loads/stores run a req/ack access to data memory and
// then emit a single writeback record. mem_blocked stalls the ALU while an
// access is outstanding, up to and including the writeback cycle.
//   clk, reset                 : clock, synchronous active-high reset
//   exe_mem/result/rflags/...  : ALU result and memory-op descriptor
//   mem_blocked                : stage busy, ALU must hold
//   dmem_*                     : data-memory request/response
//   wb_*                       : registered writeback record (wb_valid pulse)
module mem_stage
    import mem_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 256,
    parameter int unsigned REG_W       = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               exe_mem,
    input  logic [DATA_W-1:0]  result,
    input  logic [FLAGS_W-1:0] rflags,
    input  logic [1:0]         mem_op,
    input  logic [XLEN-1:0]    mem_addr,
    input  logic [1:0]         mem_size,
    input  logic               mem_sext,
    input  logic [REG_W-1:0]   dest_reg,
    output logic               mem_blocked,
    output logic               dmem_req,
    output logic               dmem_we,
    output logic [XLEN-1:0]    dmem_addr,
    output logic [1:0]         dmem_size,
    output logic [XLEN-1:0]    dmem_wdata,
    input  logic               dmem_ack,
    input  logic [XLEN-1:0]    dmem_rdata,
    output logic               wb_valid,
    output logic [REG_W-1:0]   wb_reg,
    output logic [DATA_W-1:0]  wb_data,
    output logic [FLAGS_W-1:0] wb_rflags,
    output logic               wb_store,
    output logic               wb_err
);

    mem_state_t          state, state_d;
    mem_lat_t            lat, lat_d;
    logic [REG_W-1:0]    dest_q, dest_d;
    logic [TMO_W-1:0]    cnt, cnt_d, cnt_inc;
    logic                timeout_hit;
    logic [XLEN-1:0]     load_val_c;
    memop_t              op_in;

    logic                blocked_d, req_d, we_d, wb_valid_d, wb_store_d, wb_err_d;
    logic [XLEN-1:0]     addr_d, wdata_d;
    logic [1:0]          size_d;
    logic [REG_W-1:0]    wb_reg_d;
    logic [DATA_W-1:0]   wb_data_d;
    logic [FLAGS_W-1:0]  wb_rflags_d;

    load_extend u_load_extend (
        .rdata   (dmem_rdata),
        .size    (lat.size),
        .sext    (lat.sext),
        .value_c (load_val_c)
    );

    assign op_in       = memop_t'(mem_op);
    assign cnt_inc     = cnt + TMO_W'(1);
    // cnt holds completed WAIT cycles; fire at the end of the ACK_TIMEOUT-th one.
    assign timeout_hit = (ACK_TIMEOUT != 0) && (cnt_inc == TMO_W'(ACK_TIMEOUT));

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state;
        lat_d       = lat;
        dest_d      = dest_q;
        cnt_d       = cnt;
        blocked_d   = mem_blocked;
        req_d       = dmem_req;
        we_d        = dmem_we;
        addr_d      = dmem_addr;
        size_d      = dmem_size;
        wdata_d     = dmem_wdata;
        wb_valid_d  = 1'b0;
        wb_store_d  = 1'b0;
        wb_err_d    = 1'b0;
        wb_reg_d    = wb_reg;
        wb_data_d   = wb_data;
        wb_rflags_d = wb_rflags;

        case (state)
            IDLE: begin
                // Clears the hold left over from a just-finished access.
                blocked_d = 1'b0;
                if (exe_mem && !mem_blocked) begin
                    if (op_in == MEMOP_LOAD || op_in == MEMOP_STORE) begin
                        lat_d     = '{op: op_in, size: memsize_t'(mem_size),
                                      sext: mem_sext, rflags: rflags};
                        dest_d    = dest_reg;
                        cnt_d     = '0;
                        blocked_d = 1'b1;
                        req_d     = 1'b1;
                        we_d      = (op_in == MEMOP_STORE);
                        addr_d    = mem_addr;
                        size_d    = mem_size;
                        wdata_d   = result[XLEN-1:0];
                        state_d   = REQ;
                    end else begin
                        wb_valid_d  = 1'b1;
                        wb_reg_d    = dest_reg;
                        wb_data_d   = result;
                        wb_rflags_d = rflags;
                    end
                end
            end
            REQ, WAIT: begin
                if (dmem_ack) begin
                    req_d       = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_reg_d    = dest_q;
                    wb_rflags_d = lat.rflags;
                    if (lat.op == MEMOP_STORE) begin
                        wb_store_d = 1'b1;
                        wb_data_d  = '0;
                    end else begin
                        wb_data_d  = {{XLEN{1'b0}}, load_val_c};
                    end
                    state_d = IDLE;
                end else if (state == REQ) begin
                    state_d = WAIT;
                end else if (timeout_hit) begin
                    req_d       = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_err_d    = 1'b1;
                    wb_reg_d    = dest_q;
                    wb_data_d   = '0;
                    wb_rflags_d = lat.rflags;
                    state_d     = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            lat         <= '0;
            dest_q      <= '0;
            cnt         <= '0;
            mem_blocked <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            dmem_addr   <= '0;
            dmem_size   <= '0;
            dmem_wdata  <= '0;
            wb_valid    <= 1'b0;
            wb_reg      <= '0;
            wb_data     <= '0;
            wb_rflags   <= '0;
            wb_store    <= 1'b0;
            wb_err      <= 1'b0;
        end else begin
            state       <= state_d;
            lat         <= lat_d;
            dest_q      <= dest_d;
            cnt         <= cnt_d;
            mem_blocked <= blocked_d;
            dmem_req    <= req_d;
            dmem_we     <= we_d;
            dmem_addr   <= addr_d;
            dmem_size   <= size_d;
            dmem_wdata  <= wdata_d;
            wb_valid    <= wb_valid_d;
            wb_reg      <= wb_reg_d;
            wb_data     <= wb_data_d;
            wb_rflags   <= wb_rflags_d;
            wb_store    <= wb_store_d;
            wb_err      <= wb_err_d;
        end
    end

    // The ALU must never present a result while the stage is blocked.
    a_no_exe_when_blocked: assert property (@(posedge clk) disable iff (reset)
        !(exe_mem && mem_blocked));

endmodule
